// File: rtl/cacheline_arbiter_pkg.sv
// arbiter_pkg: shared types for the cacheline arbiter
package arbiter_pkg;
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
   typedef enum logic {REQ_I, REQ_D} req_id_t;
   typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
endpackage

// File: rtl/cacheline_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector favouring the requester not granted last
module rr_pick2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic winner,
   output logic valid
);
   import arbiter_pkg::*;
   // on a tie the side that did not win last time goes next
   always_comb begin
      winner = (req_i && req_d) ? ((last_grant == REQ_I) ? REQ_D : REQ_I) : (req_d ? REQ_D : REQ_I);
      valid  = req_i | req_d;
   end
endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one physical-memory cacheline port between I-cache and D-cache
module cacheline_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pmem_read,
   input  logic              i_pmem_write,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic [LINE_W-1:0] i_pmem_wdata,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);
   import arbiter_pkg::*;

   arb_state_t        state;
   req_id_t           last_grant;
   mem_op_t           cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LINE_W-1:0] cmd_wdata;
   logic              win;
   logic              win_valid;
   req_id_t           win_id;
   mem_op_t           win_op;

   rr_pick2 u_pick (
      .req_i      (i_pmem_read | i_pmem_write),
      .req_d      (d_pmem_read | d_pmem_write),
      .last_grant (last_grant),
      .winner     (win),
      .valid      (win_valid)
   );

   // a requester asserting both strobes is treated as a write
   always_comb begin
      win_id = req_id_t'(win);
      win_op = ((win_id == REQ_I) ? i_pmem_write : d_pmem_write) ? OP_WRITE : OP_READ;
   end

   // grant FSM: latch the winner's command in IDLE, release on mem_resp
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= REQ_D;
         cmd_op     <= OP_READ;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
      end else if (state == IDLE) begin
         if (win_valid) begin
            state      <= (win_id == REQ_I) ? SERVE_I : SERVE_D;
            last_grant <= win_id;
            cmd_op     <= win_op;
            cmd_addr   <= (win_id == REQ_I) ? i_pmem_address : d_pmem_address;
            cmd_wdata  <= (win_id == REQ_I) ? i_pmem_wdata : d_pmem_wdata;
         end
      end else if (mem_resp) begin
         state <= IDLE;
      end
   end

   // downstream command from latched registers; resp routed only to the granted cache
   always_comb begin
      mem_read     = (state != IDLE) && (cmd_op == OP_READ);
      mem_write    = (state != IDLE) && (cmd_op == OP_WRITE);
      mem_address  = cmd_addr;
      mem_wdata    = cmd_wdata;
      i_pmem_resp  = (state == SERVE_I) && mem_resp;
      d_pmem_resp  = (state == SERVE_D) && mem_resp;
      i_pmem_rdata = mem_rdata;
      d_pmem_rdata = mem_rdata;
   end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: vector table, corner sequences and randomized model check
module tb_cacheline_arbiter;
   logic         clk = 0;
   logic         rst = 1;
   logic         i_rd = 0, i_wr = 0, d_rd = 0, d_wr = 0, mem_resp = 0;
   logic [31:0]  i_addr = 0, d_addr = 0;
   logic [255:0] i_wd = 0, d_wd = 0, mem_rdata = 0;
   logic [255:0] i_rdata, d_rdata, mem_wdata;
   logic [31:0]  mem_address;
   logic         i_resp, d_resp, mem_read, mem_write;
   int           checks = 0, errors = 0;

   localparam logic [255:0] A5   = {32{8'hA5}};
   localparam logic [255:0] DEAD = {8{32'hDEADBEEF}};

   cacheline_arbiter dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_rd), .i_pmem_write(i_wr), .i_pmem_address(i_addr), .i_pmem_wdata(i_wd),
      .i_pmem_rdata(i_rdata), .i_pmem_resp(i_resp),
      .d_pmem_read(d_rd), .d_pmem_write(d_wr), .d_pmem_address(d_addr), .d_pmem_wdata(d_wd),
      .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ird, iwr; logic [31:0] ia;
      logic drd, dwr; logic [31:0] da;
      logic rsp;
      logic mr, mw; logic [31:0] ma; logic ir, dr;
   } vec_t;
   vec_t tab[19];

   // spec-level model: who owns the port, what was latched, who won last
   int           m_owner, m_last;
   logic         m_w;
   logic [31:0]  m_addr;
   logic [255:0] m_wd;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0; mem_resp = 0;
      i_addr = 0; d_addr = 0; i_wd = 0; d_wd = 0;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs();
      tick(); tick();
      rst = 0;
      m_owner = -1; m_last = 1; m_w = 0; m_addr = 0; m_wd = 0;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // advance the model across one clock edge using the inputs now applied
   task automatic model_edge();
      bit ri, rd;
      int id;
      ri = i_rd | i_wr;
      rd = d_rd | d_wr;
      if (m_owner < 0) begin
         if (ri || rd) begin
            id = (ri && rd) ? 1 - m_last : (ri ? 0 : 1);
            m_owner = id; m_last = id;
            m_w    = id == 0 ? i_wr : d_wr;
            m_addr = id == 0 ? i_addr : d_addr;
            m_wd   = id == 0 ? i_wd : d_wd;
         end
      end else if (mem_resp) m_owner = -1;
   endtask

   initial begin
      tab[0]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   0, 0, 0, 32'h0,    0, 0};
      tab[1]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   0, 1, 0, 32'h1000, 0, 0};
      tab[2]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   0, 1, 0, 32'h1000, 0, 0};
      tab[3]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   0, 1, 0, 32'h1000, 0, 0};
      tab[4]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   0, 1, 0, 32'h1000, 0, 0};
      tab[5]  = '{1, 0, 32'h1000, 0, 0, 32'h0,   1, 1, 0, 32'h1000, 1, 0};
      tab[6]  = '{0, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 32'h1000, 0, 0};
      tab[7]  = '{1, 0, 32'h100,  1, 0, 32'h200, 0, 0, 0, 32'h1000, 0, 0};
      tab[8]  = '{1, 0, 32'h100,  1, 0, 32'h200, 0, 1, 0, 32'h200,  0, 0};
      tab[9]  = '{1, 0, 32'h100,  1, 0, 32'h200, 1, 1, 0, 32'h200,  0, 1};
      tab[10] = '{1, 0, 32'h100,  1, 0, 32'h200, 0, 0, 0, 32'h200,  0, 0};
      tab[11] = '{1, 0, 32'h100,  1, 0, 32'h200, 0, 1, 0, 32'h100,  0, 0};
      tab[12] = '{1, 0, 32'h100,  1, 0, 32'h200, 1, 1, 0, 32'h100,  1, 0};
      tab[13] = '{0, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 32'h100,  0, 0};
      tab[14] = '{0, 0, 32'h0,    0, 0, 32'h0,   1, 0, 0, 32'h100,  0, 0};
      tab[15] = '{0, 0, 32'h0,    0, 1, 32'h300, 0, 0, 0, 32'h100,  0, 0};
      tab[16] = '{0, 0, 32'h0,    1, 1, 32'h300, 0, 0, 1, 32'h300,  0, 0};
      tab[17] = '{0, 0, 32'h0,    0, 1, 32'h300, 1, 0, 1, 32'h300,  0, 1};
      tab[18] = '{0, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 32'h300,  0, 0};

      // reset state, checked while reset is held
      #2;
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_resps", {i_resp, d_resp}, 0);
      do_reset();
      mem_rdata = A5;

      // vector table: one row per cycle
      for (int r = 0; r < 19; r++) begin
         tick();
         i_rd = tab[r].ird; i_wr = tab[r].iwr; i_addr = tab[r].ia;
         d_rd = tab[r].drd; d_wr = tab[r].dwr; d_addr = tab[r].da;
         mem_resp = tab[r].rsp;
         settle();
         chk($sformatf("row%0d_mem_read", r), mem_read, tab[r].mr);
         chk($sformatf("row%0d_mem_write", r), mem_write, tab[r].mw);
         chk($sformatf("row%0d_mem_address", r), mem_address, tab[r].ma);
         chk($sformatf("row%0d_i_resp", r), i_resp, tab[r].ir);
         chk($sformatf("row%0d_d_resp", r), d_resp, tab[r].dr);
         chk($sformatf("row%0d_i_rdata", r), i_rdata, A5);
      end

      // simultaneous requests after reset: I first, D two cycles after I's resp
      do_reset();
      i_rd = 1; i_addr = 32'h100; d_rd = 1; d_addr = 32'h200;
      settle(); chk("sim_grant_cycle_strobe", {mem_read, mem_write}, 0);
      tick(); settle(); chk("sim_i_first", mem_address, 32'h100); chk("sim_i_read", mem_read, 1);
      tick(); mem_resp = 1; settle(); chk("sim_i_resp", {i_resp, d_resp}, 2'b10);
      tick(); mem_resp = 0; i_rd = 0; settle(); chk("sim_idle_gap", mem_read, 0);
      tick(); settle(); chk("sim_d_addr_n2", mem_address, 32'h200); chk("sim_d_read", mem_read, 1);
      tick(); mem_resp = 1; settle(); chk("sim_d_resp", {i_resp, d_resp}, 2'b01);
      tick(); clear_inputs();

      // D writeback, I waiting, then D refill
      do_reset();
      d_wr = 1; d_addr = 32'h300; d_wd = DEAD;
      tick(); i_rd = 1; i_addr = 32'h500; settle();
      chk("wb_mem_write", mem_write, 1); chk("wb_addr", mem_address, 32'h300); chk("wb_wdata", mem_wdata, DEAD);
      tick();
      tick(); mem_resp = 1; d_wr = 0; d_rd = 1; d_addr = 32'h340; settle();
      chk("wb_d_resp", {i_resp, d_resp}, 2'b01);
      tick(); mem_resp = 0; settle(); chk("wb_idle", {mem_read, mem_write}, 0);
      tick(); settle(); chk("wb_i_between", mem_address, 32'h500); chk("wb_i_read", mem_read, 1);
      tick(); mem_resp = 1; settle(); chk("wb_i_resp", {i_resp, d_resp}, 2'b10);
      tick(); mem_resp = 0; i_rd = 0;
      tick(); settle(); chk("wb_refill_addr", mem_address, 32'h340); chk("wb_refill_read", mem_read, 1);
      tick(); mem_resp = 1; settle(); chk("wb_refill_resp", {i_resp, d_resp}, 2'b01);
      tick(); clear_inputs();

      // inputs change and strobe drops mid-service
      tick(); d_rd = 1; d_addr = 32'h400;
      tick(); d_addr = 32'h480; d_rd = 0; settle();
      chk("chg_addr_held", mem_address, 32'h400); chk("chg_read", mem_read, 1);
      tick(); mem_resp = 1; settle();
      chk("chg_d_resp", {i_resp, d_resp}, 2'b01); chk("chg_addr_resp", mem_address, 32'h400);
      tick(); mem_resp = 0;

      // stray resp in IDLE, then reset during SERVE_I
      tick(); mem_resp = 1; settle();
      chk("stray_resp", {i_resp, d_resp}, 0); chk("stray_strobe", {mem_read, mem_write}, 0);
      tick(); mem_resp = 0; i_rd = 1; i_addr = 32'h600;
      tick(); settle(); chk("pre_rst_serving", mem_read, 1);
      #1 rst = 1; mem_resp = 1;
      #1;
      chk("rst_mid_read", mem_read, 0); chk("rst_mid_addr", mem_address, 0); chk("rst_mid_resp", {i_resp, d_resp}, 0);
      tick(); rst = 0; mem_resp = 0; i_addr = 32'h700; d_rd = 1; d_addr = 32'h800; settle();
      chk("post_rst_idle", {mem_read, mem_write}, 0);
      tick(); settle(); chk("post_rst_i_wins", mem_address, 32'h700);
      tick(); mem_resp = 1;
      tick(); clear_inputs();

      // fairness under saturation
      do_reset();
      i_rd = 1; i_addr = 32'hA00; d_wr = 1; d_addr = 32'hB00;
      for (int t = 0; t < 10; t++) begin
         tick(); settle();
         chk($sformatf("fair%0d_owner", t), mem_address, (t % 2 == 0) ? 32'hA00 : 32'hB00);
         tick(); mem_resp = 1; settle();
         chk($sformatf("fair%0d_resp", t), {i_resp, d_resp}, (t % 2 == 0) ? 2'b10 : 2'b01);
         tick(); mem_resp = 0; settle();
         chk($sformatf("fair%0d_gap", t), {mem_read, mem_write}, 0);
      end

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         model_edge();
         tick();
         i_rd = $urandom_range(0, 1); i_wr = ($urandom_range(0, 3) == 0);
         d_rd = $urandom_range(0, 1); d_wr = ($urandom_range(0, 3) == 0);
         i_addr = $urandom; d_addr = $urandom;
         i_wd = rnd256(); d_wd = rnd256(); mem_rdata = rnd256();
         mem_resp = ($urandom_range(0, 2) == 0);
         settle();
         chk("rnd_mem_read", mem_read, m_owner >= 0 && !m_w);
         chk("rnd_mem_write", mem_write, m_owner >= 0 && m_w);
         chk("rnd_mem_address", mem_address, m_addr);
         chk("rnd_mem_wdata", mem_wdata, m_wd);
         chk("rnd_i_resp", i_resp, m_owner == 0 && mem_resp);
         chk("rnd_d_resp", d_resp, m_owner == 1 && mem_resp);
         chk("rnd_d_rdata", d_rdata, mem_rdata);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

- Shares the single physical-memory cacheline port between the I-cache and the D-cache.
- Each cache's control FSM keeps `pmem_read`/`pmem_write` high until it sees `pmem_resp`, exactly as against a private memory.
- The arbiter grants one requester at a time, round-robin when both request, and latches that requester's command.
- It drives the downstream cacheline adaptor and routes the response pulse back to the granted cache only.

## Interface

Parameters:
- `ADDR_W`, default 32: cacheline address width.
- `LINE_W`, default 256: cacheline data width.

Ports:
- `clk`  in  1  — the only clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `i_pmem_read`, `i_pmem_write`  in  1  — I-cache request strobes.
- `i_pmem_address`  in  `ADDR_W`  — I-cache line address.
- `i_pmem_wdata`  in  `LINE_W`  — I-cache write line.
- `i_pmem_rdata`  out  `LINE_W`  — I-cache read line.
- `i_pmem_resp`  out  1  — I-cache completion pulse.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp` — same widths and directions as the I-cache set, for the D-cache.
- `mem_read`, `mem_write`  out  1  — downstream strobes.
- `mem_address`  out  `ADDR_W`  — downstream line address.
- `mem_wdata`  out  `LINE_W`  — downstream write line.
- `mem_rdata`  in  `LINE_W`  — downstream read line.
- `mem_resp`  in  1  — downstream completion pulse.

## Operation

- **States:**
  - `IDLE`: nothing granted; downstream strobes low.
  - `SERVE_I`: I-cache granted.
  - `SERVE_D`: D-cache granted.
- **Request:** a requester is requesting when its read or write strobe is high. If both strobes are high, the request is treated as a write.
- **Arbitration in `IDLE`:**
  - Only one requester requesting → grant it.
  - Both requesting → grant the one not recorded in `last_grant`.
  - Neither requesting → stay in `IDLE`.
- **At the grant edge:**
  - Latch `op` (read or write), the address and the write data into `cmd_op`, `cmd_addr` and `cmd_wdata`.
  - Update `last_grant` to the granted requester.
  - Move to `SERVE_x`.
- **In `SERVE_x`:**
  - Drive `mem_read`/`mem_write` from `cmd_op`, `mem_address = cmd_addr`, `mem_wdata = cmd_wdata`.
  - Requester input changes are ignored until completion.
- **Completion:** `mem_resp` high in `SERVE_x` → `x_pmem_resp = 1` combinationally in that same cycle, and the state returns to `IDLE`.
- **Read data:** `mem_rdata` is forwarded unregistered to both `i_pmem_rdata` and `d_pmem_rdata`. Each cache must sample it only on its own resp.
- **Response gating:** `i_pmem_resp`/`d_pmem_resp` are never high outside their matching `SERVE` state. `mem_resp` seen in `IDLE` is ignored.
- **Requester drops its strobe mid-service:** the transaction still completes downstream and the resp pulse is still issued.
- **D-cache writeback followed by refill:** these are two independent grants. A waiting I-cache request may be served between them; this is correct behaviour, not a hazard.

## Timing

- **Reset (asynchronous, takes effect immediately):**
  - state = `IDLE`, `last_grant = D`, so the I-cache wins the first tie.
  - `cmd_*` cleared to 0.
  - All outputs 0: both resps, both strobes, `mem_address`, `mem_wdata`.
- **Reset mid-transaction:** the downstream strobe drops immediately, the transaction is abandoned and no resp is issued.
- **Request latency:**
  - Request visible in `IDLE` during cycle 0 → `mem_read`/`mem_write` high from cycle 1.
  - Downstream strobes are never high in the cycle a grant is decided.
- **Completion timing:**
  - `mem_resp` in cycle N → `x_pmem_resp` in cycle N, and downstream strobes low in cycle N+1 (`IDLE`).
  - The next downstream strobe is high no earlier than cycle N+2, which guarantees at least one idle cycle between transactions.
- **Throughput:** at most one outstanding transaction; no pipelining.
- **Starvation:** with both caches continuously requesting, grants strictly alternate.

## Structure

- **Package `arbiter_pkg`:**
  - `arb_state_t` enum {`IDLE`, `SERVE_I`, `SERVE_D`}.
  - `req_id_t` enum {`REQ_I`, `REQ_D`}.
  - `mem_op_t` enum {`OP_READ`, `OP_WRITE`}.
- **Sub-module:** `rr_pick2`, a combinational two-way round-robin selector (inputs: two request bits and `last_grant`; output: winner id and a valid bit).
- **Top-level:** the FSM, the command registers and the output muxing stay in `cacheline_arbiter`.

## Test plan

- **Lone I-cache read.** I-cache read to `0x0000_1000` in cycle 0 → `mem_read=1`, `mem_address=0x0000_1000` from cycle 1; `mem_resp` in cycle 5 with rdata `0xA5…A5` → `i_pmem_resp=1` in cycle 5 with `i_pmem_rdata=0xA5…A5`; `d_pmem_resp=0` throughout.
- **Simultaneous requests after reset.** I-cache read `0x100` and D-cache read `0x200` asserted together → I-cache served first; after its resp, `mem_address=0x200` exactly two cycles after that resp.
- **D-cache writeback then refill, I-cache waiting.** D-cache write `0x300` with wdata `0xDEAD…` → `mem_write=1`, `mem_wdata` correct; after resp, the pending I-cache request is granted before the D-cache read `0x340`; all three complete in that order.
- **Inputs change mid-service.** Change `d_pmem_address` and drop the D-cache strobe during `SERVE_D` → `mem_address` holds the latched value; `d_pmem_resp` still pulses on `mem_resp`.
- **Stray `mem_resp` and reset mid-service.** `mem_resp` in `IDLE` → no resp to either cache. `rst` asserted during `SERVE_I` → all outputs 0 in the same cycle; after release the arbiter is `IDLE`, and with both caches requesting the I-cache wins.
- **Fairness under saturation.** Both caches requesting continuously for 10 transactions → grant sequence I,D,I,D,…, with each `x_pmem_resp` issued only to the granted cache.
